pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/bit_sync.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and status widths for the PLL reset sequencer
package pll_seq_pkg;

  localparam int STATE_W  = 3;
  localparam int RELOCK_W = 4;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } seq_state_e;

  function automatic logic [RELOCK_W-1:0] relock_sat_inc(input logic [RELOCK_W-1:0] cnt);
    return (cnt == {RELOCK_W{1'b1}}) ? cnt : cnt + RELOCK_W'(1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer for a single asynchronous level
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock qualification and staged downstream reset release
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGE_GAP_CYCLES    = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                err_clr,
  output logic                pll_rst,
  output logic [1:0]          rst_out_n,
  output logic [STATE_W-1:0]  state,
  output logic                lock_err,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int TMAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int TMAX_B = (LOCK_TIMEOUT_CYCLES > STAGE_GAP_CYCLES) ? LOCK_TIMEOUT_CYCLES : STAGE_GAP_CYCLES;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TW-1:0] TIMER_MAX    = TW'(TMAX - 1);
  localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(STAGE_GAP_CYCLES - 1);
  // The WAIT_LOCK sample that moved us into STABLE is the first stable cycle.
  localparam logic [TW-1:0] STABLE_LAST  = TW'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  logic lock_s;

  seq_state_e          state_q,     state_d;
  logic [TW-1:0]       timer_q,     timer_d;
  logic [RW-1:0]       retry_q,     retry_d;
  logic [RELOCK_W-1:0] relock_q,    relock_d;
  logic                lock_err_q,  lock_err_d;
  logic                pll_rst_q,   pll_rst_d;
  logic [1:0]          rst_out_n_q, rst_out_n_d;

  bit_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
    retry_d    = retry_q;
    relock_d   = relock_q;
    lock_err_d = err_clr ? 1'b0 : lock_err_q;

    case (state_q)
      RESET_PLL: begin
        if (timer_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          retry_d = retry_q + RW'(1);
          state_d = (retry_d == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = RELEASE;
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          state_d  = RESET_PLL;
          relock_d = relock_sat_inc(relock_q);
          retry_d  = '0;
        end else if (state_q == RELEASE && timer_q == GAP_LAST) begin
          state_d = RUN;
        end
      end
      FAULT: begin
        if (err_clr) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    if (state_d == RUN && state_q != RUN) retry_d = '0;
    if (state_d != state_q) timer_d = '0;
    // A fault entry outranks a coincident clear request.
    if (state_d == FAULT && state_q != FAULT) lock_err_d = 1'b1;

    pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
    rst_out_n_d = (state_d == RUN) ? 2'b11 : (state_d == RELEASE) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q     <= RESET_PLL;
      timer_q     <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      lock_err_q  <= 1'b0;
      pll_rst_q   <= 1'b1;
      rst_out_n_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      lock_err_q  <= lock_err_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_n_q <= rst_out_n_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign rst_out_n  = rst_out_n_q;
  assign state      = state_q;
  assign lock_err   = lock_err_q;
  assign relock_cnt = relock_q;

endmodule
